// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_I_BUSY,
        ARB_D_BUSY
    } arb_state_t;

    // RISC-V "addi x0, x0, 0", presented to the core whenever no fetched word is available.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/arb_timeout_counter.sv
// Watchdog for a single bus access: counts busy cycles without an ack and flags
// the cycle in which the access must be force-completed. TIMEOUT=0 disables it.
module arb_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [7:0] LAST_CNT = (TIMEOUT != 0) ? 8'(TIMEOUT - 1) : 8'hFF;

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at the top value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (TIMEOUT != 0) && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between the core's fetch and data sides.
// Data has priority; after MAX_D_BURST data grants with a fetch waiting, the
// fetch wins. A watchdog converts a missing ack into an error completion.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_D_BURST = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] inst,
    output logic        inst_stall,
    output logic        inst_fault,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        mem_err
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);

    arb_state_t  state_q, state_d;
    logic [3:0]  burst_q, burst_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;

    logic        busy;
    logic        tmo_expire;
    logic        tmo_hit;
    logic        done;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    assign busy      = (state_q != ARB_IDLE);
    // A real ack in the expiry cycle takes precedence over the watchdog.
    assign tmo_hit   = busy && tmo_expire && !mem_ack;
    assign done      = busy && (mem_ack || tmo_hit);
    assign rsp_rdata = mem_ack ? mem_rdata : 32'h0;
    assign rsp_err   = mem_ack ? mem_err : 1'b1;

    arb_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (!busy),
        .enable_i (busy && !mem_ack),
        .expire_o (tmo_expire)
    );

    // Arbitration, request latching and core-side response muxing.
    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        inst        = NOP_INST;
        inst_stall  = if_req;
        inst_fault  = 1'b0;
        d_rdata     = 32'h0;
        d_stall     = d_req;
        d_err       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (if_req && (!d_req || (burst_q == BURST_MAX))) begin
                    state_d     = ARB_I_BUSY;
                    burst_d     = 4'd0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = 32'h0;
                    mem_wmask_d = 4'h0;
                end else if (d_req) begin
                    state_d     = ARB_D_BUSY;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_we ? d_wdata : 32'h0;
                    mem_wmask_d = d_we ? d_wmask : 4'h0;
                    if (if_req && (burst_q != BURST_MAX)) begin
                        burst_d = burst_q + 4'd1;
                    end
                end
            end
            ARB_I_BUSY: begin
                if (done) begin
                    state_d = ARB_IDLE;
                    // A redirected pc makes the returned word stale: drop it silently.
                    if (mem_addr_q == if_addr) begin
                        inst_stall = 1'b0;
                        inst       = rsp_rdata;
                        inst_fault = rsp_err;
                    end
                end
            end
            ARB_D_BUSY: begin
                if (done) begin
                    state_d = ARB_IDLE;
                    d_stall = 1'b0;
                    // A flushed access still finishes on the bus, but the core sees nothing.
                    if (d_req) begin
                        d_rdata = mem_we_q ? 32'h0 : rsp_rdata;
                        d_err   = rsp_err;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, burst counter and latched bus request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            burst_q     <= 4'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wmask_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
        end
    end

    assign mem_req   = busy;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mem_port_arbiter;

    localparam int          MAXB = 4;
    localparam int          TMO  = 8;
    localparam logic [31:0] K    = 32'hCAFE_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] inst;
    logic        inst_stall;
    logic        inst_fault;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [3:0]  d_wmask = 4'h0;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        mem_err = 1'b0;

    mem_port_arbiter #(
        .MAX_D_BURST(MAXB),
        .TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .inst       (inst),
        .inst_stall (inst_stall),
        .inst_fault (inst_fault),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wmask    (d_wmask),
        .d_rdata    (d_rdata),
        .d_stall    (d_stall),
        .d_err      (d_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: ack lat cycles after mem_req rises, data = addr ^ K.
    int lat = 2;
    bit no_ack = 1'b0;
    bit err_cfg = 1'b0;
    int r_age = 0;
    always @(posedge clk) begin
        #1;
        if (reset || !mem_req) begin
            r_age = 0;
            mem_ack = 1'b0;
            mem_err = 1'b0;
            mem_rdata = 32'h0;
        end else begin
            r_age++;
            if (!no_ack && r_age == lat + 1) begin
                mem_ack = 1'b1;
                mem_err = err_cfg;
                mem_rdata = mem_addr ^ K;
            end else begin
                mem_ack = 1'b0;
                mem_err = 1'b0;
                mem_rdata = 32'h0;
            end
        end
    end

    // Transaction-level model and observation log.
    bit          m_busy = 1'b0;
    bit          m_data = 1'b0;
    bit          m_we = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [3:0]  m_wmask = 4'h0;
    int          m_age = 0;
    int          m_burst = 0;

    logic        prev_req = 1'b0;
    logic [31:0] gbits = 32'h0;
    int          gcnt = 0;
    logic [31:0] last_gaddr = 32'h0;
    logic        last_gwe = 1'b0;
    logic [3:0]  last_gwmask = 4'h0;
    int          n_inst_ok = 0;
    logic [31:0] last_inst = 32'h0;
    int          n_derr = 0;
    logic [31:0] last_drdata = 32'h0;

    always @(negedge clk) begin : compare
        bit          c_done;
        bit          c_err;
        logic [31:0] c_rd;
        logic        e_istall, e_ifault, e_dstall, e_derr;
        logic [31:0] e_inst, e_drdata;
        if (reset) begin
            m_busy = 1'b0;
            m_burst = 0;
            m_age = 0;
            check("rst_mem_req", 32'(mem_req), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_mem_addr", mem_addr, 32'h0);
            check("rst_mem_wdata", mem_wdata, 32'h0);
            check("rst_mem_wmask", 32'(mem_wmask), 32'h0);
            check("rst_inst", inst, NOP);
            check("rst_inst_stall", 32'(inst_stall), 32'(if_req));
            check("rst_inst_fault", 32'(inst_fault), 32'd0);
            check("rst_d_stall", 32'(d_stall), 32'(d_req));
            check("rst_d_rdata", d_rdata, 32'h0);
            check("rst_d_err", 32'(d_err), 32'd0);
        end else begin
            c_done   = m_busy && (mem_ack || (m_age == TMO - 1));
            c_err    = mem_ack ? mem_err : 1'b1;
            c_rd     = mem_ack ? mem_rdata : 32'h0;
            e_istall = if_req;
            e_inst   = NOP;
            e_ifault = 1'b0;
            e_dstall = d_req;
            e_drdata = 32'h0;
            e_derr   = 1'b0;
            if (c_done && m_data) begin
                e_dstall = 1'b0;
                if (d_req) begin
                    e_derr = c_err;
                    if (!m_we) e_drdata = c_rd;
                end
            end
            if (c_done && !m_data && (m_addr == if_addr)) begin
                e_istall = 1'b0;
                e_inst   = c_rd;
                e_ifault = c_err;
            end
            check("mem_req", 32'(mem_req), 32'(m_busy));
            if (m_busy) begin
                check("mem_we", 32'(mem_we), 32'(m_we));
                check("mem_addr", mem_addr, m_addr);
                check("mem_wdata", mem_wdata, m_wdata);
                check("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
            end
            check("inst_stall", 32'(inst_stall), 32'(e_istall));
            check("inst", inst, e_inst);
            check("inst_fault", 32'(inst_fault), 32'(e_ifault));
            check("d_stall", 32'(d_stall), 32'(e_dstall));
            check("d_rdata", d_rdata, e_drdata);
            check("d_err", 32'(d_err), 32'(e_derr));
            // Advance the model to what the next cycle must look like.
            if (m_busy) begin
                if (c_done) m_busy = 1'b0;
                else m_age++;
            end else if (if_req && (!d_req || m_burst == MAXB)) begin
                m_busy = 1'b1; m_data = 1'b0; m_age = 0; m_burst = 0;
                m_we = 1'b0; m_addr = if_addr; m_wdata = 32'h0; m_wmask = 4'h0;
            end else if (d_req) begin
                m_busy = 1'b1; m_data = 1'b1; m_age = 0;
                m_we = d_we; m_addr = d_addr;
                m_wdata = d_we ? d_wdata : 32'h0;
                m_wmask = d_we ? d_wmask : 4'h0;
                if (if_req && m_burst < MAXB) m_burst++;
            end
        end
        if (mem_req && !prev_req) begin
            gcnt++;
            gbits = {gbits[30:0], (mem_we | mem_addr[31])};
            last_gaddr = mem_addr;
            last_gwe = mem_we;
            last_gwmask = mem_wmask;
        end
        prev_req = mem_req;
        if (mem_req && if_req && !inst_stall) begin
            n_inst_ok++;
            last_inst = inst;
        end
        if (d_err) n_derr++;
        if (mem_req && d_req && !d_stall) last_drdata = d_rdata;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (mem_ack !== 1'b1 && n < 40);
        check({tag, "_ack_seen"}, 32'(mem_ack), 32'd1);
        tick();
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (mem_req !== 1'b1 && n < 20);
        check({tag, "_req_seen"}, 32'(mem_req), 32'd1);
    endtask

    initial begin : stim
        int base;
        int n;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Fetch only, ack 2 cycles after mem_req.
        base = n_inst_ok;
        if_req = 1'b1; if_addr = 32'h100;
        repeat (4) tick();
        if_req = 1'b0;
        repeat (2) tick();
        check("t1_ok_cycles", 32'(n_inst_ok - base), 32'd1);
        check("t1_inst", last_inst, 32'hCAFE_0100);
        check("t1_addr", last_gaddr, 32'h100);
        check("t1_wmask", 32'(last_gwmask), 32'h0);

        // Simultaneous store and fetch: data first, then fetch.
        gbits = 32'h0; gcnt = 0;
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678; d_wmask = 4'b0011;
        wait_ack("t2_store");
        check("t2_store_we", 32'(last_gwe), 32'd1);
        check("t2_store_wmask", 32'(last_gwmask), 32'h3);
        check("t2_store_addr", last_gaddr, 32'h200);
        d_req = 1'b0; d_we = 1'b0; d_wmask = 4'h0;
        wait_ack("t2_fetch");
        if_req = 1'b0;
        tick();
        check("t2_grants", 32'(gcnt), 32'd2);
        check("t2_order", gbits, 32'h2);
        check("t2_inst", last_inst, 32'hCAFE_0104);

        // Burst limit: D,D,D,D,I repeated twice.
        gbits = 32'h0; gcnt = 0;
        if_req = 1'b1; if_addr = 32'h108;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0010;
        repeat (10) wait_ack("t3");
        d_req = 1'b0; if_req = 1'b0;
        tick();
        check("t3_grants", 32'(gcnt), 32'd10);
        check("t3_order", gbits, 32'h3DE);
        check("t3_rdata", last_drdata, 32'h4AFE_0010);

        // pc redirect mid-fetch: stale word dropped, new address fetched.
        base = n_inst_ok;
        if_req = 1'b1; if_addr = 32'h100;
        wait_req("t4");
        tick();
        if_addr = 32'h200;
        wait_ack("t4_old");
        check("t4_dropped", 32'(n_inst_ok - base), 32'd0);
        wait_ack("t4_new");
        if_req = 1'b0;
        tick();
        check("t4_ok", 32'(n_inst_ok - base), 32'd1);
        check("t4_addr", last_gaddr, 32'h200);
        check("t4_inst", last_inst, 32'hCAFE_0200);

        // Watchdog on a load with no ack.
        no_ack = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0020;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req) n++;
            if (d_err) break;
        end
        check("t5_err", 32'(d_err), 32'd1);
        check("t5_cycle", 32'(n), 32'd8);
        check("t5_rdata", d_rdata, 32'h0);
        check("t5_stall", 32'(d_stall), 32'd0);
        tick();
        d_req = 1'b0; no_ack = 1'b0;
        check("t5_idle", 32'(mem_req), 32'd0);
        tick();

        // Fetch error -> one-cycle inst_fault.
        err_cfg = 1'b1;
        if_req = 1'b1; if_addr = 32'h300;
        n = 0;
        do begin
            tick();
            n++;
        end while (mem_ack !== 1'b1 && n < 20);
        check("t6_fault", 32'(inst_fault), 32'd1);
        check("t6_stall", 32'(inst_stall), 32'd0);
        tick();
        check("t6_fault_end", 32'(inst_fault), 32'd0);
        if_req = 1'b0; err_cfg = 1'b0;
        tick();

        // Flushed load with an error response: d_err suppressed.
        base = n_derr;
        err_cfg = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0040;
        wait_req("t8");
        tick();
        d_req = 1'b0;
        wait_ack("t8");
        check("t8_no_err", 32'(n_derr - base), 32'd0);
        err_cfg = 1'b0;

        // Async reset during D_BUSY drops mem_req immediately.
        lat = 5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0030;
        wait_req("t7");
        tick();
        #1 reset = 1'b1;
        #1;
        check("t7_req", 32'(mem_req), 32'd0);
        check("t7_addr", mem_addr, 32'h0);
        tick();
        d_req = 1'b0; reset = 1'b0; lat = 2;
        repeat (3) tick();
        check("t7_idle", 32'(mem_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
